mem_ctrl_port: RTL and testbench

MEM_CTRL_PORT -- requirements
Module: mem_ctrl_port

---
 rtl/mem_ctrl_port_pkg.sv | 31 +++
 rtl/mem_ctrl_port.sv | 133 +++++++++++++
 tb/tb_mem_ctrl_port.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_port_pkg.sv
// rtl/mem_ctrl_port_pkg.sv - shared constants, state encoding and width decode for mem_ctrl_port
package mem_ctrl_port_pkg;

  localparam int AddrLen = 32;
  localparam int InstLen = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INST_RD = 3'd1,
    DATA_RD = 3'd2,
    DATA_WR = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [1:0] WidthByte = 2'b00;
  localparam logic [1:0] WidthHalf = 2'b01;
  localparam logic [1:0] WidthWord = 2'b10;

  localparam logic [AddrLen-1:0] IoAddrTx   = 32'h0003_0000;
  localparam logic [AddrLen-1:0] IoAddrStat = 32'h0003_0004;

  // Code 11 is not a legal width and falls back to a full word.
  function automatic logic [2:0] width_bytes(input logic [1:0] w);
    case (w)
      WidthByte: return 3'd1;
      WidthHalf: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_port.sv
// rtl/mem_ctrl_port.sv - byte-serial RAM port arbitrating instruction fetches and data loads/stores (option: IO_BUFFER_STALL_EN)
module mem_ctrl_port
  import mem_ctrl_port_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
`ifdef IO_BUFFER_STALL_EN
  input  logic               io_buffer_full,
`endif
  input  logic               inst_needed,
  input  logic [AddrLen-1:0] inst_addr_to_mem,
  output logic [InstLen-1:0] inst_mem,
  output logic               inst_available_o,
  input  logic               data_needed,
  input  logic               data_wr,
  input  logic [AddrLen-1:0] data_addr,
  input  logic [1:0]         data_width,
  input  logic [31:0]        data_wdata,
  output logic [31:0]        data_rdata,
  output logic               data_done,
  output logic [AddrLen-1:0] mem_a,
  output logic [7:0]         mem_dout,
  output logic               mem_wr,
  input  logic [7:0]         mem_din
);

  state_t             state, state_nxt;
  logic [2:0]         cnt, cnt_nxt, nbytes;
  logic [AddrLen-1:0] base, addr_k;
  logic [31:0]        wdata, rbuf, rbuf_nxt;
  logic               last_data;
  logic               accept_data, accept_inst, ld_inst, ld_data, stall;

  assign addr_k           = base + {{(AddrLen-3){1'b0}}, cnt};
  assign data_done        = (state == DONE) && last_data;
  assign inst_available_o = (state == DONE) && !last_data;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    rbuf_nxt    = rbuf;
    accept_data = 1'b0;
    accept_inst = 1'b0;
    ld_inst     = 1'b0;
    ld_data     = 1'b0;
    stall       = 1'b0;
    mem_a       = '0;
    mem_dout    = '0;
    mem_wr      = 1'b0;
    case (state)
      IDLE: begin
        // A pending fetch wins right after a data transaction so neither side starves.
        if (data_needed && !(inst_needed && last_data)) begin
          accept_data = 1'b1;
          state_nxt   = data_wr ? DATA_WR : DATA_RD;
          cnt_nxt     = '0;
          rbuf_nxt    = '0;
        end else if (inst_needed) begin
          accept_inst = 1'b1;
          state_nxt   = INST_RD;
          cnt_nxt     = '0;
          rbuf_nxt    = '0;
        end
      end
      INST_RD, DATA_RD: begin
        if (state == INST_RD && !inst_needed) begin
          state_nxt = IDLE;
        end else begin
          if (cnt < nbytes) mem_a = addr_k;
          // RAM answers one cycle late, so lane cnt-1 arrives while address cnt is out.
          case (cnt)
            3'd1:    rbuf_nxt[7:0]   = mem_din;
            3'd2:    rbuf_nxt[15:8]  = mem_din;
            3'd3:    rbuf_nxt[23:16] = mem_din;
            3'd4:    rbuf_nxt[31:24] = mem_din;
            default: ;
          endcase
          cnt_nxt = cnt + 3'd1;
          if (cnt == nbytes) begin
            state_nxt = DONE;
            ld_inst   = (state == INST_RD);
            ld_data   = (state == DATA_RD);
          end
        end
      end
      DATA_WR: begin
        mem_a    = addr_k;
        mem_dout = wdata[{cnt[1:0], 3'b000} +: 8];
`ifdef IO_BUFFER_STALL_EN
        stall = io_buffer_full && (addr_k == IoAddrTx || addr_k == IoAddrStat);
`endif
        mem_wr = !stall;
        if (!stall) begin
          cnt_nxt = cnt + 3'd1;
          if (cnt == nbytes - 3'd1) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      nbytes     <= '0;
      base       <= '0;
      wdata      <= '0;
      rbuf       <= '0;
      last_data  <= 1'b0;
      inst_mem   <= '0;
      data_rdata <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rbuf  <= rbuf_nxt;
      if (accept_data) begin
        base      <= data_addr;
        nbytes    <= width_bytes(data_width);
        wdata     <= data_wdata;
        last_data <= 1'b1;
      end else if (accept_inst) begin
        base      <= inst_addr_to_mem;
        nbytes    <= 3'd4;
        last_data <= 1'b0;
      end
      if (ld_inst) inst_mem <= rbuf_nxt;
      if (ld_data) data_rdata <= rbuf_nxt;
    end
  end

endmodule

// File: tb/tb_mem_ctrl_port.sv
// tb/tb_mem_ctrl_port.sv - randomized self-checking bench for mem_ctrl_port against a byte-array memory model
module tb_mem_ctrl_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_needed, inst_available_o;
  logic [31:0] inst_addr_to_mem, inst_mem;
  logic        data_needed, data_wr, data_done;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [1:0]  data_width;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout, mem_din;
  logic        mem_wr;
`ifdef IO_BUFFER_STALL_EN
  logic        io_buffer_full = 1'b0;
`endif

  mem_ctrl_port dut (
    .clk(clk), .rst(rst),
`ifdef IO_BUFFER_STALL_EN
    .io_buffer_full(io_buffer_full),
`endif
    .inst_needed(inst_needed), .inst_addr_to_mem(inst_addr_to_mem),
    .inst_mem(inst_mem), .inst_available_o(inst_available_o),
    .data_needed(data_needed), .data_wr(data_wr), .data_addr(data_addr),
    .data_width(data_width), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_done(data_done), .mem_a(mem_a), .mem_dout(mem_dout),
    .mem_wr(mem_wr), .mem_din(mem_din)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  int inst_pulses = 0;
  logic [31:0] exp_inst = '0;
  logic [31:0] exp_data = '0;

  logic [7:0] ram     [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  function automatic int nbytes_of(input bit is_inst, input logic [1:0] w);
    if (is_inst) return 4;
    return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input int n);
    logic [31:0] v = '0;
    for (int k = 0; k < n; k++) v = v | (32'(ref_rd(addr + 32'(k))) << (8 * k));
    return v;
  endfunction

  // Byte-wide RAM with one cycle of read latency.
  always @(posedge clk) begin
    mem_din <= ram_rd(mem_a);
    if (mem_wr === 1'b1) begin
      ram[mem_a] = mem_dout;
      wr_cnt++;
    end
  end

  always @(negedge clk) if (inst_available_o === 1'b1) inst_pulses++;

  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    ram[a] = b;
    ref_mem[a] = b;
  endtask

  task automatic wait_pulse(input bit is_inst, output int lat, output logic [31:0] got);
    lat = 0;
    got = '0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (is_inst ? inst_available_o : data_done) begin
        lat = c;
        got = is_inst ? inst_mem : data_rdata;
        break;
      end
    end
  endtask

  task automatic run_txn(input bit is_inst, input bit wr, input logic [31:0] addr,
                         input logic [1:0] w, input logic [31:0] wd);
    int n, lat;
    logic [31:0] got, exp;
    n = nbytes_of(is_inst, w);
    exp = ref_load(addr, n);
    @(negedge clk);
    wr_cnt = 0;
    if (is_inst) begin
      inst_needed = 1'b1; inst_addr_to_mem = addr;
    end else begin
      data_needed = 1'b1; data_wr = wr; data_addr = addr; data_width = w; data_wdata = wd;
    end
    wait_pulse(is_inst, lat, got);
    inst_needed = 1'b0;
    data_needed = 1'b0;
    check_eq("latency", 64'(lat), 64'(wr ? n + 1 : n + 2));
    check_eq("write_count", 64'(wr_cnt), 64'(wr ? n : 0));
    if (wr) begin
      logic [31:0] got_m = '0, exp_m = '0;
      for (int k = 0; k < n; k++) begin
        ref_mem[addr + 32'(k)] = wd[8*k +: 8];
        got_m[8*k +: 8] = ram_rd(addr + 32'(k));
        exp_m[8*k +: 8] = wd[8*k +: 8];
      end
      check_eq("store_bytes", 64'(got_m), 64'(exp_m));
    end else begin
      check_eq(is_inst ? "inst_data" : "load_data", 64'(got), 64'(exp));
      if (is_inst) exp_inst = exp; else exp_data = exp;
    end
    repeat (2) @(negedge clk);
    check_eq("hold_outputs", {inst_mem, data_rdata}, {exp_inst, exp_data});
  endtask

  initial begin
    int lat, t_d, t_i;
    logic [31:0] got, got_d, got_i;
    rst = 1'b0;
    inst_needed = 0; inst_addr_to_mem = '0;
    data_needed = 0; data_wr = 0; data_addr = '0; data_width = '0; data_wdata = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs",
             {inst_mem, data_rdata, mem_a, mem_dout, mem_wr, data_done, inst_available_o},
             '0);
    rst = 1'b1;
    @(negedge clk);

    // Instruction fetch of a known little-endian word.
    poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h00); poke(32'h103, 8'h00);
    run_txn(1, 0, 32'h100, 2'b10, '0);
    check_eq("inst_0x100", 64'(inst_mem), 64'h0000_0513);

    // Simultaneous requests: data first, instruction after the DONE cycle.
    @(negedge clk);
    data_needed = 1; data_wr = 0; data_addr = 32'h200; data_width = 2'b10;
    inst_needed = 1; inst_addr_to_mem = 32'h200;
    t_d = 0; t_i = 0; got_d = '0; got_i = '0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (data_done && t_d == 0) begin t_d = c; got_d = data_rdata; data_needed = 0; end
      if (inst_available_o && t_i == 0) begin t_i = c; got_i = inst_mem; inst_needed = 0; end
      if (t_d != 0 && t_i != 0) break;
    end
    inst_needed = 0; data_needed = 0;
    check_eq("both_data_time", 64'(t_d), 64'd6);
    check_eq("both_inst_time", 64'(t_i), 64'd13);
    check_eq("both_values", {got_d, got_i}, {ref_load(32'h200, 4), ref_load(32'h200, 4)});
    exp_data = ref_load(32'h200, 4);
    exp_inst = exp_data;

    // Half store straddling the top of the address space.
    run_txn(0, 1, 32'hFFFF_FFFF, 2'b01, 32'h0000_BEEF);
    check_eq("wrap_bytes", {ram_rd(32'hFFFF_FFFF), ram_rd(32'h0)}, {8'hEF, 8'hBE});

    // Fetch abandoned at T+2; FSM must take a new request at T+3.
    @(negedge clk);
    inst_pulses = 0;
    inst_needed = 1; inst_addr_to_mem = 32'h300;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    inst_needed = 0;
    @(posedge clk); @(negedge clk);
    data_needed = 1; data_wr = 0; data_addr = 32'h300; data_width = 2'b00;
    wait_pulse(0, lat, got);
    data_needed = 0;
    check_eq("abort_then_load_latency", 64'(lat), 64'd3);
    check_eq("abort_then_load_data", 64'(got), 64'(ref_load(32'h300, 1)));
    exp_data = ref_load(32'h300, 1);
    repeat (4) @(negedge clk);
    check_eq("abort_no_pulse", 64'(inst_pulses), 64'd0);

    // Reset during the second byte of a word store.
    @(negedge clk);
    data_needed = 1; data_wr = 1; data_addr = 32'h2000; data_width = 2'b10; data_wdata = 32'hAABB_CCDD;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    rst = 1'b0;
    data_needed = 0;
    #1;
    check_eq("reset_mem_wr", 64'(mem_wr), 64'd0);
    repeat (2) begin
      @(negedge clk);
      check_eq("reset_hold_outputs",
               {inst_mem, data_rdata, mem_a, mem_dout, mem_wr, data_done, inst_available_o}, '0);
    end
    rst = 1'b1;
    exp_inst = '0; exp_data = '0;
    ref_mem[32'h2000] = 8'hDD;
    check_eq("reset_byte1_untouched", 64'(ram_rd(32'h2001)), 64'(ref_rd(32'h2001)));
    run_txn(0, 0, 32'h2000, 2'b10, '0);

`ifdef IO_BUFFER_STALL_EN
    begin
      bit stalled_ok = 1;
      @(negedge clk);
      io_buffer_full = 1; wr_cnt = 0;
      data_needed = 1; data_wr = 1; data_addr = 32'h0003_0000; data_width = 2'b00; data_wdata = 32'h41;
      lat = 0;
      for (int c = 1; c <= 20; c++) begin
        @(posedge clk); @(negedge clk);
        if (c <= 5 && mem_wr !== 1'b0) stalled_ok = 0;
        if (c == 6) io_buffer_full = 0;
        if (data_done) begin lat = c; break; end
      end
      data_needed = 0;
      check_eq("stall_no_write", 64'(stalled_ok), 64'd1);
      check_eq("stall_latency", 64'(lat), 64'd7);
      check_eq("stall_write_count", 64'(wr_cnt), 64'd1);
      check_eq("stall_byte", 64'(ram_rd(32'h0003_0000)), 64'h41);
      ref_mem[32'h0003_0000] = 8'h41;
      repeat (2) @(negedge clk);
    end
`endif

    // Randomized mix of fetches, loads and stores.
    for (int i = 0; i < 40; i++) begin
      int kind;
      logic [31:0] a;
      kind = int'($urandom_range(0, 2));
      a = 32'h1000 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      if (kind == 0) run_txn(1, 0, a & 32'hFFFF_FFFC, 2'b10, '0);
      else run_txn(0, kind == 2, a, 2'($urandom_range(0, 3)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
